// File: rtl/sdram_req_queue.sv
// sdram_req_queue: request front-end for sdram_cnt.
// Buffers client read/write requests in an in-order FIFO and issues them one
// at a time to the controller using its rdy/valid protocol. Read data comes
// back to the client in request order. A sticky err flags a stalled controller.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_*             client request channel (valid/ready, we, addr, data)
//   rsp_valid/data    one-cycle read-data pulse; data holds between pulses
//   count, busy, err  occupancy, activity and sticky timeout status
//   mem_en/we/addr/data  drive sdram_cnt en/we/addr_in/data_in
//   mem_rdy/valid/rdata  from sdram_cnt rdy/valid/data_out
module sdram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AW-1:0]            req_addr,
  input  logic [DW-1:0]            req_data,
  output logic                     rsp_valid,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  input  logic                     mem_rdy,
  input  logic                     mem_valid,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = AW + DW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DATA,
    WAIT_RDY
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_fifo [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_tmr;
  logic            r_live;
  logic            r_err;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_data;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;

  logic            w_push;
  logic            w_pop;
  logic            w_tmo;
  logic [EW-1:0]   w_head;

  // r_live keeps req_ready low while in reset and until the first clock after
  // release, even though the registered count is already zero.
  assign req_ready = r_live && (r_count != CW'(DEPTH));
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == IDLE) && (r_count != '0) && mem_rdy;
  assign w_tmo     = (r_tmr == TW'(TIMEOUT - 1));
  assign w_head    = r_fifo[r_rptr];

  assign count     = r_count;
  assign busy      = (r_count != '0) || (r_state != IDLE);
  assign err       = r_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {req_we, req_addr, req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_tmr       <= '0;
      r_live      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_mem_en    <= 1'b0;
      r_rsp_valid <= 1'b0;

      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // The wait counter restarts on each state change; a timeout drops the
      // in-flight request and returns to IDLE without any response.
      case (r_state)
        IDLE: begin
          r_tmr <= '0;
          if (w_pop) begin
            r_mem_we   <= w_head[EW-1];
            r_mem_addr <= w_head[EW-2:DW];
            r_mem_data <= w_head[DW-1:0];
            r_mem_en   <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_tmr   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mem_rdy) begin
            r_tmr   <= '0;
            r_state <= r_mem_we ? WAIT_RDY : WAIT_DATA;
          end else if (w_tmo) begin
            r_tmr   <= '0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        WAIT_DATA: begin
          if (mem_valid) begin
            r_tmr       <= '0;
            r_rsp_data  <= mem_rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= WAIT_RDY;
          end else if (w_tmo) begin
            r_tmr   <= '0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        WAIT_RDY: begin
          if (mem_rdy) begin
            r_tmr   <= '0;
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_tmr   <= '0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        default: begin
          r_tmr   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Testbench for sdram_req_queue: a behavioural controller stub answers the
// mem_* handshake, and a reference model (request queue plus memory image)
// predicts every issued command and every read response.
module tb_sdram_req_queue;

  localparam int DEPTH   = 4;
  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] count;
  logic          busy;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_rdy;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  sdram_req_queue #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .count(count), .busy(busy), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdy(mem_rdy), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- controller stub (changes on falling edge) -------------
  typedef enum {S_IDLE, S_DROP, S_RD, S_RD_END, S_RET} sst_t;
  sst_t          s_st;
  int            s_d;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic          s_rdy;
  int            stub_mode = 0;  // 0 normal, 1 rdy held low, 2 never drops rdy
  int            rd_extra  = 0;
  logic [DW-1:0] smem [0:(1<<AW)-1];

  assign mem_rdy = (stub_mode == 1) ? 1'b0 : s_rdy;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      s_st      <= S_IDLE;
      s_d       <= 0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_rdy     <= 1'b1;
      mem_valid <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (s_st)
        S_IDLE: if (mem_en && stub_mode == 0) begin
          s_we   <= mem_we;
          s_addr <= mem_addr;
          if (mem_we) smem[mem_addr] <= mem_data;
          s_d    <= int'($urandom_range(2, 0));
          s_st   <= S_DROP;
        end
        S_DROP: if (s_d == 0) begin
          s_rdy <= 1'b0;
          s_d   <= s_we ? int'($urandom_range(2, 0)) : rd_extra + int'($urandom_range(2, 0));
          s_st  <= s_we ? S_RET : S_RD;
        end else s_d <= s_d - 1;
        S_RD: if (s_d == 0) begin
          mem_valid <= 1'b1;
          mem_rdata <= smem[s_addr];
          s_st      <= S_RD_END;
        end else s_d <= s_d - 1;
        S_RD_END: begin
          mem_valid <= 1'b0;
          mem_rdata <= $urandom;
          s_d       <= int'($urandom_range(2, 0));
          s_st      <= S_RET;
        end
        S_RET: if (s_d == 0) begin
          s_rdy <= 1'b1;
          s_st  <= S_IDLE;
        end else s_d <= s_d - 1;
        default: s_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- reference model and monitor ----------------------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t          iss_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            en_pulses  = 0;
  int            rsp_pulses = 0;
  logic          prev_en    = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_en) begin
        req_t r;
        en_pulses++;
        chk("mem_en_one_cycle", {63'd0, prev_en}, 64'd0);
        chk("issue_expected", {63'd0, iss_q.size() != 0}, 64'd1);
        if (iss_q.size() != 0) begin
          r = iss_q.pop_front();
          chk("issue_cmd", {19'd0, mem_we, mem_addr, mem_data}, {19'd0, r});
        end
      end
      prev_en = mem_en;
      if (rsp_valid) begin
        rsp_pulses++;
        chk("rsp_expected", {63'd0, rsp_q.size() != 0}, 64'd1);
        if (rsp_q.size() != 0) chk("rsp_data_order", {32'd0, rsp_data}, {32'd0, rsp_q.pop_front()});
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  // Drive one request; the model is updated once the handshake completes.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("push_accepted", {63'd0, ok}, 64'd1);
    if (ok) begin
      iss_q.push_back('{we: we, a: a, d: d});
      if (we) ref_mem[a] = d;
      else    rsp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy && iss_q.size() == 0 && rsp_q.size() == 0) done = 1;
    end
    chk("drain_complete", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0;
    logic [AW-1:0] addrs [64];
    bit seen;

    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_data = '0;

    // Reset: held 5 cycles with a request presented.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_mem_en",    {63'd0, mem_en},    64'd0);
    chk("rst_count",     {61'd0, count},     64'd0);
    chk("rst_err",       {63'd0, err},       64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1 chk("release_ready_before_clk", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("release_ready_after_clk", {63'd0, req_ready}, 64'd1);

    // Write then read.
    e0 = en_pulses; r0 = rsp_pulses;
    push(1'b1, 12'h123, 32'hDEADBEEF);
    push(1'b0, 12'h123, 32'h0);
    wait_drain();
    chk("wr_rd_en_pulses", 64'(en_pulses - e0), 64'd2);
    chk("wr_rd_rsp_pulses", 64'(rsp_pulses - r0), 64'd1);
    chk("wr_rd_rsp_data", {32'd0, rsp_data}, {32'd0, 32'hDEADBEEF});

    // Fill / full with the controller stalled.
    stub_mode = 1;
    e0 = en_pulses;
    for (int i = 0; i < 4; i++) push(1'b1, AW'(12'h200 + i), $urandom);
    chk("full_count", {61'd0, count}, 64'(DEPTH));
    chk("full_ready", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h2FF; req_data = 32'h55AA55AA;
    seen = 0;
    repeat (5) begin
      if (req_ready) seen = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("fifth_not_accepted", {63'd0, seen}, 64'd0);
    chk("fifth_count", {61'd0, count}, 64'(DEPTH));
    stub_mode = 0;
    wait_drain();
    chk("fill_en_pulses", 64'(en_pulses - e0), 64'd4);

    // Ordering and pointer wrap: random writes then reads of the same addresses.
    r0 = rsp_pulses;
    for (int i = 0; i < 64; i++) begin
      addrs[i] = AW'($urandom_range(12'hFFE, 0));
      push(1'b1, addrs[i], $urandom);
    end
    for (int i = 0; i < 64; i++) push(1'b0, addrs[i], $urandom);
    wait_drain();
    chk("order_rsp_pulses", 64'(rsp_pulses - r0), 64'd64);

    // Timeout: controller never drops rdy after en.
    stub_mode = 2;
    push(1'b1, 12'hFFF, 32'h0BADF00D);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_en) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("tmo_issue_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;  // now in WAIT_BUSY
    repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
    chk("tmo_err_not_early", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    chk("tmo_err_set", {63'd0, err}, 64'd1);
    chk("tmo_back_idle", {63'd0, busy}, 64'd0);
    stub_mode = 0;
    r0 = rsp_pulses;
    push(1'b0, 12'h123, 32'h0);
    wait_drain();
    chk("tmo_next_served", 64'(rsp_pulses - r0), 64'd1);
    chk("tmo_err_sticky", {63'd0, err}, 64'd1);

    // Asynchronous reset in the middle of a read.
    rd_extra = 8;
    push(1'b0, 12'h123, 32'h0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (s_st == S_RD) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("midread_reached", {63'd0, seen}, 64'd1);
    r0 = rsp_pulses;
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_en",    {63'd0, mem_en},    64'd0);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_count",     {61'd0, count},     64'd0);
    chk("arst_busy",      {63'd0, busy},      64'd0);
    chk("arst_err",       {63'd0, err},       64'd0);
    chk("arst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("arst_mem_addr",  {52'd0, mem_addr},  64'd0);
    iss_q.delete();
    rsp_q.delete();
    rd_extra = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_no_rsp_after", 64'(rsp_pulses - r0), 64'd0);
    chk("arst_idle_after", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
